instr_prefetch_reg: RTL and testbench

Parametrised successor to the single-byte opcode/address instruction register. It accepts a byte-serial instruction stream from the memory data register over a valid/ready handshake. It assembles each instruction as one opcode byte plus 0 or ADDR_BYTES operand bytes, then queues complete instructions in a small FIFO. The control unit pops instructions via a valid/ready handshake, so fetch and decode are decoupled, and it can discard queued work with a flush on branch.

---
 rtl/instr_pkg.sv | 20 ++
 rtl/instr_fifo.sv | 60 ++++++
 rtl/instr_prefetch_reg.sv | 115 +++++++++++
 tb/tb_instr_prefetch_reg.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types and widths for the instruction prefetch register
// Default widths here size instr_t; the top may be elaborated with other widths.
package instr_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ADDR_BYTES_DEF = 2;
  localparam int IMPLIED_BIT    = DATA_W_DEF - 1;

  typedef enum logic {
    S_OPC  = 1'b0,
    S_ADDR = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]                opcode;
    logic [ADDR_BYTES_DEF*DATA_W_DEF-1:0] addr;
    logic                                 implied;
  } instr_t;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - DEPTH-entry synchronous queue of packed instructions
// Head is combinational from the read slot and forced to zero when empty.
import instr_pkg::*;

module instr_fifo #(
  parameter int W     = $bits(instr_t),
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign count   = cnt;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_prefetch_reg.sv
// rtl/instr_prefetch_reg.sv - byte-serial instruction assembler feeding a prefetch queue
// One opcode byte plus 0 or ADDR_BYTES little-endian operand bytes per instruction.
import instr_pkg::*;

module instr_prefetch_reg #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_BYTES = ADDR_BYTES_DEF,
  parameter int DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DATA_W-1:0]            mdr,
  input  logic                         mdr_valid,
  output logic                         mdr_ready,
  input  logic                         flush,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic [DATA_W-1:0]            opcode,
  output logic [ADDR_BYTES*DATA_W-1:0] addr,
  output logic                         implied,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW       = ADDR_BYTES * DATA_W;
  localparam int EW       = DATA_W + AW + 1;
  localparam int IW       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int MODE_BIT = (DATA_W == DATA_W_DEF) ? IMPLIED_BIT : DATA_W - 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ADDR_BYTES - 1);

  state_t            state, state_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] opc_q, opc_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic              accept;
  logic              push;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head;
  logic              full;
  logic              empty;

  assign mdr_ready   = ~full & ~flush;
  assign accept      = mdr_valid & mdr_ready;
  assign instr_valid = ~empty;
  assign {opcode, addr, implied} = head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_OPC;
      idx    <= '0;
      opc_q  <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      opc_q  <= opc_n;
      addr_q <= addr_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    opc_n     = opc_q;
    addr_n    = addr_q;
    push      = 1'b0;
    push_data = {opc_q, addr_q, 1'b0};
    if (flush) begin
      state_n = S_OPC;
      idx_n   = '0;
    end else if (accept) begin
      case (state)
        S_OPC: begin
          opc_n  = mdr;
          addr_n = '0;
          if (mdr[MODE_BIT]) begin
            push      = 1'b1;
            push_data = {mdr, {AW{1'b0}}, 1'b1};
          end else begin
            state_n = S_ADDR;
            idx_n   = '0;
          end
        end
        S_ADDR: begin
          addr_n[int'(idx)*DATA_W +: DATA_W] = mdr;
          if (idx == LAST_IDX) begin
            push      = 1'b1;
            push_data = {opc_q, addr_n, 1'b0};
            state_n   = S_OPC;
            idx_n     = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
        default: state_n = S_OPC;
      endcase
    end
  end

  instr_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (instr_ready),
    .flush     (flush),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_instr_prefetch_reg.sv
// tb/tb_instr_prefetch_reg.sv - self-checking bench for instr_prefetch_reg
// Queue-based reference model plus directed literal expectations.
module tb_instr_prefetch_reg;

  localparam int DATA_W     = 8;
  localparam int ADDR_BYTES = 2;
  localparam int DEPTH      = 2;

  logic        clk;
  logic        reset_n;
  logic [7:0]  mdr;
  logic        mdr_valid;
  logic        mdr_ready;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  opcode;
  logic [15:0] addr;
  logic        implied;
  logic [1:0]  count;

  int checks = 0;
  int errors = 0;

  instr_prefetch_reg #(
    .DATA_W     (DATA_W),
    .ADDR_BYTES (ADDR_BYTES),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mdr         (mdr),
    .mdr_valid   (mdr_valid),
    .mdr_ready   (mdr_ready),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .addr        (addr),
    .implied     (implied),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: raw bytes of the instruction in progress, and finished instructions.
  typedef struct {
    logic [7:0]  opc;
    logic [15:0] ad;
    logic        imp;
  } m_t;

  m_t         mq[$];
  logic [7:0] cur[$];
  m_t         e;
  bit         m_acc;
  bit         m_pop;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      cur.delete();
    end else if (flush) begin
      mq.delete();
      cur.delete();
    end else begin
      m_acc = mdr_valid && (mq.size() < DEPTH);
      m_pop = instr_ready && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        cur.push_back(mdr);
        if (cur[0][7] || cur.size() == 1 + ADDR_BYTES) begin
          e.opc = cur[0];
          e.imp = cur[0][7];
          e.ad  = 16'h0;
          for (int i = 1; i < cur.size(); i++) e.ad = e.ad | (16'(cur[i]) << (8 * (i - 1)));
          mq.push_back(e);
          cur.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("cmp_valid", instr_valid, mq.size() > 0);
      chk("cmp_count", count, mq.size());
      chk("cmp_mdr_ready", mdr_ready, (mq.size() < DEPTH) && !flush);
      chk("cmp_opcode", opcode, (mq.size() > 0) ? mq[0].opc : 8'h0);
      chk("cmp_addr", addr, (mq.size() > 0) ? mq[0].ad : 16'h0);
      chk("cmp_implied", implied, (mq.size() > 0) ? mq[0].imp : 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    mdr       = b;
    mdr_valid = 1'b1;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = mdr_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    mdr_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_gap(input logic [7:0] b);
    mdr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_byte(b);
  endtask

  task automatic pop_one();
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b1;
    mdr         = 8'h00;
    mdr_valid   = 1'b0;
    flush       = 1'b0;
    instr_ready = 1'b0;
    #1 reset_n  = 1'b0;
    #2;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_count", count, 2'd0);
    chk("rst_ready", mdr_ready, 1'b1);
    chk("rst_opcode", opcode, 8'h00);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Addressed instruction, little-endian operand
    send_byte(8'h12);
    send_byte(8'h34);
    chk("partial_not_visible", instr_valid, 1'b0);
    send_byte(8'h56);
    chk("t1_valid", instr_valid, 1'b1);
    chk("t1_opcode", opcode, 8'h12);
    chk("t1_addr", addr, 16'h5634);
    chk("t1_implied", implied, 1'b0);
    chk("t1_count", count, 2'd1);
    pop_one();
    chk("t1_popped", count, 2'd0);

    // Implied opcode, then the next byte must start a new instruction
    send_byte(8'h81);
    chk("t2_opcode", opcode, 8'h81);
    chk("t2_addr", addr, 16'h0000);
    chk("t2_implied", implied, 1'b1);
    send_byte(8'h05);
    chk("t2_next_is_opcode", count, 2'd1);
    send_byte(8'h11);
    send_byte(8'h22);

    // Full queue backpressure and wrap-around ordering
    chk("t3_full_count", count, 2'd2);
    chk("t3_full_ready", mdr_ready, 1'b0);
    mdr       = 8'h83;
    mdr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t3_held_count", count, 2'd2);
    chk("t3_held_head", opcode, 8'h81);
    instr_ready = 1'b1;
    @(posedge clk);
    #1;
    instr_ready = 1'b0;
    chk("t3_pop_count", count, 2'd1);
    chk("t3_pop_ready", mdr_ready, 1'b1);
    chk("t3_pop_head", opcode, 8'h05);
    chk("t3_pop_addr", addr, 16'h2211);
    @(posedge clk);
    #1;
    mdr_valid = 1'b0;
    chk("t3_refill_count", count, 2'd2);
    pop_one();
    chk("t3_wrap_opcode", opcode, 8'h83);
    chk("t3_wrap_implied", implied, 1'b1);
    pop_one();
    chk("t3_drained", instr_valid, 1'b0);

    // Gaps between bytes
    send_gap(8'h07);
    send_gap(8'hCD);
    send_gap(8'hAB);
    chk("t4_opcode", opcode, 8'h07);
    chk("t4_addr", addr, 16'hABCD);
    pop_one();

    // Flush with one queued instruction and a partial one
    send_byte(8'h09);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h0A);
    send_byte(8'h33);
    chk("t5_pre_count", count, 2'd1);
    mdr       = 8'h44;
    mdr_valid = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    mdr_valid = 1'b0;
    chk("t5_flush_count", count, 2'd0);
    chk("t5_flush_valid", instr_valid, 1'b0);
    send_byte(8'h22);
    chk("t5_22_is_opcode", count, 2'd0);
    send_byte(8'h55);
    send_byte(8'h66);
    chk("t5_opcode", opcode, 8'h22);
    chk("t5_addr", addr, 16'h6655);
    pop_one();

    // Asynchronous reset in the middle of an operand
    send_byte(8'h85);
    send_byte(8'h03);
    send_byte(8'h10);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", instr_valid, 1'b0);
    chk("t6_rst_count", count, 2'd0);
    chk("t6_rst_opcode", opcode, 8'h00);
    chk("t6_rst_addr", addr, 16'h0000);
    chk("t6_rst_implied", implied, 1'b0);
    chk("t6_rst_ready", mdr_ready, 1'b1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("t6_opcode", opcode, 8'h01);
    chk("t6_addr", addr, 16'hBBAA);
    chk("t6_count", count, 2'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
